// File: rtl/reg_file_wb.sv
// reg_file_wb: architectural register file (R0..R7, SP, IH, T, RA) written by WB,
// with two decode read ports and same-cycle write-to-read bypass.
module reg_file_wb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_GPR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] ih_out,
    output logic [DATA_W-1:0] t_out,
    output logic [DATA_W-1:0] sp_out,
    output logic [15:0]       wb_count
);
    localparam int NUM_REGS = NUM_GPR + 4;
    localparam logic [ADDR_W-1:0] SP_CODE = ADDR_W'(NUM_GPR);
    localparam logic [ADDR_W-1:0] IH_CODE = ADDR_W'(NUM_GPR + 1);
    localparam logic [ADDR_W-1:0] T_CODE  = ADDR_W'(NUM_GPR + 2);
    localparam logic [ADDR_W-1:0] LIMIT   = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [15:0]       r_wb_count;
    logic              w_wr_ok;
    logic              w_byp_a;
    logic              w_byp_b;
    logic              w_byp_ih;
    logic              w_byp_t;
    logic              w_byp_sp;
    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    // Reserved codes and NONE neither write nor bypass.
    assign w_wr_ok = wb_en && (wb_addr < LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_wb_count <= '0;
        end else if (w_wr_ok) begin
            r_regs[wb_addr] <= wb_data;
            r_wb_count      <= r_wb_count + 16'd1;
        end
    end

    always_comb begin
        w_stored_a = (rd_addr_a < LIMIT) ? r_regs[rd_addr_a] : '0;
        w_stored_b = (rd_addr_b < LIMIT) ? r_regs[rd_addr_b] : '0;
        w_byp_a    = w_wr_ok && (wb_addr == rd_addr_a);
        w_byp_b    = w_wr_ok && (wb_addr == rd_addr_b);
        w_byp_ih   = w_wr_ok && (wb_addr == IH_CODE);
        w_byp_t    = w_wr_ok && (wb_addr == T_CODE);
        w_byp_sp   = w_wr_ok && (wb_addr == SP_CODE);
        rd_data_a  = w_byp_a  ? wb_data : w_stored_a;
        rd_data_b  = w_byp_b  ? wb_data : w_stored_b;
        ih_out     = w_byp_ih ? wb_data : r_regs[IH_CODE];
        t_out      = w_byp_t  ? wb_data : r_regs[T_CODE];
        sp_out     = w_byp_sp ? wb_data : r_regs[SP_CODE];
    end

    assign wb_count = r_wb_count;
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file that consumes the writeback stage's result: it is the receiving end of the WB data path.
- Holds R0–R7 plus the special registers SP, IH, T and RA.
- Serves two decode-stage read ports, and exposes IH and T directly to the writeback mux and the branch logic.
- Same-cycle write-to-read bypass, so decode never sees stale data from the instruction retiring in WB.

Parameters:
DATA_W, 16, register/data width
ADDR_W, 4, register address width
NUM_GPR, 8, general-purpose registers R0..R(NUM_GPR-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
wb_en  input  1  write-back enable from WB stage
wb_addr  input  ADDR_W  destination register code
wb_data  input  DATA_W  data selected by the WB data mux
rd_addr_a  input  ADDR_W  read port A register code
rd_addr_b  input  ADDR_W  read port B register code
rd_data_a  output  DATA_W  read port A data
rd_data_b  output  DATA_W  read port B data
ih_out  output  DATA_W  current IH value (feeds WB mux IH input)
t_out  output  DATA_W  current T value (branch compare)
sp_out  output  DATA_W  current SP value
wb_count  output  16  number of committed writes since reset

Behaviour:
- Register code map:
  - 0–7 = R0–R7
  - 8 = SP, 9 = IH, 10 = T, 11 = RA
  - 12–14 reserved; 15 = NONE
- Reset: rst sampled high at a rising edge clears every register and wb_count to 0. rst has priority over a simultaneous write. Reset mid-stream discards the in-flight write.
- Write:
  - When wb_en=1 and wb_addr is 0–11, that register takes wb_data at the rising edge, and wb_count increments by 1.
  - wb_count wraps 16'hFFFF -> 0.
  - Writes to codes 12–15 are dropped and not counted.
- Read (combinational from addr):
  - Returns the stored register value.
  - Codes 12–15 return 0.
- Bypass: if wb_en=1, wb_addr is 0–11 and wb_addr equals a read address, that port returns wb_data in the same cycle instead of the stored value. Ports A and B bypass independently, so both may bypass at once.
- ih_out, t_out and sp_out:
  - Reflect the stored register with the same bypass rule, i.e. ih_out shows wb_data during a cycle that writes IH.
  - All are 0 after reset.
- Latency:
  - Write visible through storage one cycle after the commit edge.
  - Visible via bypass in the commit cycle itself.
- No X propagation: any rd_addr value yields a defined output.
- Single write port; at most one write per cycle by construction.

Test Plan:
1. Assert rst for 1 cycle, then read all codes 0–15 on both ports -> all 0, ih_out=t_out=sp_out=0, wb_count=0.
2. Write R3=16'hBEEF, R7=16'h1234 on consecutive cycles; read A=3, B=7 afterwards -> BEEF / 1234, wb_count=2.
3. Same-cycle bypass:
   - Stimulus: wb_en=1, wb_addr=5, wb_data=16'hA5A5, with rd_addr_a=rd_addr_b=5 and R5 previously 16'h0001.
   - Response: both ports return A5A5 in that cycle and A5A5 from storage in the next.
4. Special registers:
   - Stimulus: write IH (code 9)=16'h8000, then T (code 10)=16'h0001.
   - Response: ih_out=8000 during the commit cycle and after; t_out=0001; writes to code 15 and code 13 leave all registers and wb_count unchanged.
5. Reset priority: rst=1 with wb_en=1, wb_addr=2, wb_data=16'hFFFF -> R2=0 and wb_count=0 next cycle.
6. Counter wrap: preload 65535 writes, then one more write -> wb_count=0 and the last written register holds its data.
